piece_bag_generator: RTL

- Next-generation Tetris piece source, replacing the free-running 1..3 counter.
- Draws piece IDs 1..NUM_PIECES using a "bag" scheme: every piece appears exactly once per bag, in random order.
- Randomness comes from a free-running LFSR.
- Holds a head piece plus a PREVIEW_DEPTH-entry preview queue for the game controller and the next-piece display.

---
 rtl/piece_bag_generator.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/piece_bag_generator.sv
// Bag-randomised Tetris piece source: LFSR-driven draws, one of each ID per bag, head plus preview queue.
// Define PIECE_HOLD_EN to add the hold slot (hold_req / hold_piece / hold_used).
module piece_bag_generator #(
   parameter int                NUM_PIECES    = 7,
   parameter int                PIECE_W       = 3,
   parameter int                PREVIEW_DEPTH = 3,
   parameter int                LFSR_W        = 16,
   parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
   parameter int                MAX_TRIES     = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             next_req,
   input  logic                             seed_load,
   input  logic [LFSR_W-1:0]                seed_in,
`ifdef PIECE_HOLD_EN
   input  logic                             hold_req,
   output logic [PIECE_W-1:0]               hold_piece,
   output logic                             hold_used,
`endif
   output logic [PIECE_W-1:0]               piece_out,
   output logic                             piece_valid,
   output logic [PREVIEW_DEPTH*PIECE_W-1:0] preview,
   output logic [NUM_PIECES-1:0]            bag_remaining
);

   localparam int Depth = PREVIEW_DEPTH + 1;
   localparam int CntW  = $clog2(Depth + 1);
   localparam int TryW  = $clog2(MAX_TRIES + 1);
   localparam logic [LFSR_W-1:0] LfsrMask = LFSR_W'(16'hB400);

   typedef enum logic {IDLE, DRAW} state_t;

   state_t                        state_q, state_d;
   logic [LFSR_W-1:0]             lfsr_q, lfsr_d;
   logic [NUM_PIECES-1:0]         bag_q, bag_d;
   logic [Depth-1:0][PIECE_W-1:0] queue_q, queue_d;
   logic [CntW-1:0]               count_q, count_d;
   logic [TryW-1:0]               tries_q, tries_d;
   logic                          valid_q, valid_d;
`ifdef PIECE_HOLD_EN
   logic [PIECE_W-1:0]            holdPiece_q, holdPiece_d;
   logic                          holdUsed_q, holdUsed_d;
`endif

   logic [PIECE_W-1:0]    candidate, fallbackId, acceptId;
   logic                  candHit, doPop, holdSwap, drawing, accept;
   logic [CntW-1:0]       writeSlot;
   logic [NUM_PIECES-1:0] bagCleared;

   // The descending scan leaves fallbackId at the lowest set bag bit.
   always_comb begin
      candidate  = lfsr_q[PIECE_W-1:0];
      candHit    = 1'b0;
      fallbackId = '0;
      for (int i = NUM_PIECES - 1; i >= 0; i--) begin
         if (bag_q[i]) fallbackId = PIECE_W'(i + 1);
      end
      for (int i = 0; i < NUM_PIECES; i++) begin
         if (candidate == PIECE_W'(i + 1) && bag_q[i]) candHit = 1'b1;
      end
   end

   // A pop always refills in its own cycle, so a rejected candidate there takes the fallback.
   always_comb begin
      doPop    = next_req && valid_q;
      holdSwap = 1'b0;
`ifdef PIECE_HOLD_EN
      if (hold_req && !next_req && valid_q && !holdUsed_q) begin
         if (holdPiece_q == '0) doPop = 1'b1;
         else                   holdSwap = 1'b1;
      end
`endif
      drawing   = (state_q == DRAW) || doPop;
      accept    = drawing && (candHit || doPop || tries_q == TryW'(MAX_TRIES));
      acceptId  = candHit ? candidate : fallbackId;
      writeSlot = doPop ? count_q - 1'b1 : count_q;
   end

   always_comb begin
      queue_d    = queue_q;
      count_d    = count_q;
      bag_d      = bag_q;
      tries_d    = tries_q;
      state_d    = state_q;
      bagCleared = bag_q;
`ifdef PIECE_HOLD_EN
      holdPiece_d = holdPiece_q;
      holdUsed_d  = holdUsed_q;
      if (next_req && valid_q) begin
         holdUsed_d = 1'b0;
      end else if (doPop || holdSwap) begin
         holdPiece_d = queue_q[0];
         holdUsed_d  = 1'b1;
      end
      if (holdSwap) queue_d[0] = holdPiece_q;
`endif
      if (doPop) begin
         for (int i = 0; i < Depth - 1; i++) queue_d[i] = queue_q[i + 1];
         queue_d[Depth-1] = '0;
         count_d = count_q - 1'b1;
      end
      if (accept) begin
         for (int i = 0; i < Depth; i++) begin
            if (writeSlot == CntW'(i)) queue_d[i] = acceptId;
         end
         count_d = writeSlot + 1'b1;
         for (int i = 0; i < NUM_PIECES; i++) begin
            if (acceptId == PIECE_W'(i + 1)) bagCleared[i] = 1'b0;
         end
         bag_d   = (bagCleared == '0) ? '1 : bagCleared;
         tries_d = '0;
         state_d = (count_d == CntW'(Depth)) ? IDLE : DRAW;
      end else if (drawing) begin
         tries_d = tries_q + 1'b1;
      end
      valid_d = (count_d == CntW'(Depth));
      // A zero seed would lock the LFSR, so it falls back to SEED.
      if (seed_load) lfsr_d = (seed_in == '0) ? SEED : seed_in;
      else           lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LfsrMask : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DRAW;
         lfsr_q  <= SEED;
         bag_q   <= '1;
         queue_q <= '0;
         count_q <= '0;
         tries_q <= '0;
         valid_q <= 1'b0;
`ifdef PIECE_HOLD_EN
         holdPiece_q <= '0;
         holdUsed_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         bag_q   <= bag_d;
         queue_q <= queue_d;
         count_q <= count_d;
         tries_q <= tries_d;
         valid_q <= valid_d;
`ifdef PIECE_HOLD_EN
         holdPiece_q <= holdPiece_d;
         holdUsed_q  <= holdUsed_d;
`endif
      end
   end

   assign piece_out     = queue_q[0];
   assign preview       = queue_q[Depth-1:1];
   assign piece_valid   = valid_q;
   assign bag_remaining = bag_q;
`ifdef PIECE_HOLD_EN
   assign hold_piece = holdPiece_q;
   assign hold_used  = holdUsed_q;
`endif

endmodule
